// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Control bundle between the multicycle MIPS control FSM and its datapath.
//   Datapath -> control : opcode[5:0], zero, mem_ready
//   Control -> datapath : pc_write, i_or_d, mem_read, mem_write, ir_write,
//                         mem_to_reg, reg_dst, reg_write, alu_src_a,
//                         alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
//   Status (debug)      : state[3:0], illegal, timeout
// The controller connects through the master modport; the datapath (or a
// bench standing in for it) through the slave modport.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  logic [3:0] state;
  logic       illegal;
  logic       timeout;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state, illegal, timeout
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state, illegal, timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Control FSM sequencing a multicycle MIPS datapath over a single shared
// memory. Supported instructions: R-format (0), beq (4), bne (5), lw (35),
// sw (43). Anything else traps with the sticky illegal flag.
// Memory states (FETCH, MEM_READ, MEM_WRITE) wait for mem_ready; a watchdog
// traps with the sticky timeout flag after MAX_WAIT consecutive wait cycles
// (MAX_WAIT = 0 disables the watchdog).
//
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous, active-low
//   bus   : multicycle_control_if.master (opcode/zero/mem_ready in, control
//           strobes, mux selects, alu_op, state, illegal, timeout out)
//   cycle_count[31:0], instr_count[31:0] : only when PERF_COUNT_EN is defined
//
// Optional build macro: PERF_COUNT_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int MAX_WAIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_control_if.master bus
`ifdef PERF_COUNT_EN
  ,
  output logic [31:0]          cycle_count,
  output logic [31:0]          instr_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // Counter only has to hold 0..MAX_WAIT-1: the wait cycle that would take it
  // to MAX_WAIT is the one that traps instead.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT =
      (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [5:0]        r_opcode;
  logic              r_illegal;
  logic              r_timeout;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic       w_illegal_set;
  logic       w_timeout_set;
  logic       w_in_mem_state;
  logic       w_wait_expired;

  logic       w_pc_write;
  logic       w_i_or_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_source;

  assign w_in_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);

  // mem_ready on the limit cycle still completes the access.
  assign w_wait_expired = (MAX_WAIT > 0) && (r_wait_cnt == WAIT_LIMIT) &&
                          !bus.mem_ready;

  // Next-state and control decode. Everything but pc_write/ir_write is a pure
  // function of the state, so reset forces all strobes low asynchronously.
  always_comb begin
    w_state_next  = r_state;
    w_illegal_set = 1'b0;
    w_timeout_set = 1'b0;
    w_pc_write    = 1'b0;
    w_i_or_d      = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_dst     = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_op      = 2'b00;
    w_pc_source   = 2'b00;

    unique case (r_state)
      S_IDLE: w_state_next = S_FETCH;

      S_FETCH: begin
        // PC + 4 is computed on the ALU while the instruction is read.
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_wait_expired) begin
          w_timeout_set = 1'b1;
          w_state_next  = S_TRAP;
        end
      end

      S_DECODE: begin
        // Speculative branch target lands in ALUOut for use by BRANCH.
        w_alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:   w_state_next = S_MEM_ADDR;
          OP_RTYPE:       w_state_next = S_EXECUTE;
          OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
          default: begin
            w_illegal_set = 1'b1;
            w_state_next  = S_TRAP;
          end
        endcase
      end

      S_MEM_ADDR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_state_next = (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = S_MEM_WB;
        end else if (w_wait_expired) begin
          w_timeout_set = 1'b1;
          w_state_next  = S_TRAP;
        end
      end

      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = S_FETCH;
        end else if (w_wait_expired) begin
          w_timeout_set = 1'b1;
          w_state_next  = S_TRAP;
        end
      end

      S_EXECUTE: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = 2'b10;
        w_state_next = S_R_WB;
      end

      S_R_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_state_next = S_FETCH;
      end

      S_BRANCH: begin
        // Subtract compares A and B; the taken decision is Mealy on zero.
        w_alu_src_a  = 1'b1;
        w_alu_op     = 2'b01;
        w_pc_source  = 2'b01;
        w_pc_write   = (r_opcode == OP_BEQ) ? bus.zero : ~bus.zero;
        w_state_next = S_FETCH;
      end

      S_TRAP: w_state_next = S_TRAP;

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_opcode   <= 6'd0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) begin
        r_opcode <= bus.opcode;
      end
      if (w_illegal_set) begin
        r_illegal <= 1'b1;
      end
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
      // Any state change restarts the count, so each memory state is entered
      // with a fresh budget; only stalled memory cycles advance it.
      if (w_state_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_in_mem_state && !bus.mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  assign bus.pc_write   = w_pc_write;
  assign bus.i_or_d     = w_i_or_d;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.ir_write   = w_ir_write;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.reg_write  = w_reg_write;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.pc_source  = w_pc_source;
  assign bus.state      = r_state;
  assign bus.illegal    = r_illegal;
  assign bus.timeout    = r_timeout;

`ifdef PERF_COUNT_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;
  logic        w_instr_done;

  // An instruction retires when its last state hands control back to FETCH.
  assign w_instr_done = (w_state_next == S_FETCH) &&
                        ((r_state == S_MEM_WB) || (r_state == S_MEM_WRITE) ||
                         (r_state == S_R_WB) || (r_state == S_BRANCH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= 32'd0;
      r_instr_count <= 32'd0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_TRAP)) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_instr_done) begin
        r_instr_count <= r_instr_count + 32'd1;
      end
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore/Mealy control FSM that sequences a multicycle MIPS datapath over one shared memory: instruction fetch and data load/store.
- Supports the same subset as the pipeline: R-format (opcode 0), beq (4), bne (5), lw (35), sw (43).
- Drives PC/IR write enables, memory strobes, register-file write, mux selects and the 2-bit ALUOp consumed by the ALU control unit.
- Handles memory wait states with a timeout watchdog.

Parameters:
MAX_WAIT, 16, max consecutive cycles a memory state may wait for mem_ready before trapping; 0 disables the timeout.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low.
opcode  input  6  instruction[31:26] from the instruction register.
zero  input  1  ALU zero flag.
mem_ready  input  1  memory access completes this cycle.
pc_write  output  1  PC load enable (Mealy in BRANCH).
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
ir_write  output  1  instruction register load.
mem_to_reg  output  1  register write data select: 0=ALUOut, 1=MDR.
reg_dst  output  1  write register select: 0=rt, 1=rd.
reg_write  output  1  register file write enable.
alu_src_a  output  1  0=PC, 1=register A.
alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext, 11=sign-ext<<2.
alu_op  output  2  00=add, 01=sub, 10=funct-decoded.
pc_source  output  2  00=ALU result, 01=ALUOut register.
state  output  4  current state encoding (debug).
illegal  output  1  sticky: unsupported opcode.
timeout  output  1  sticky: memory wait exceeded MAX_WAIT.

Behaviour:
- State encoding:
  - IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5
  - MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, TRAP=10
- Reset (async, reset==0):
  - state=IDLE; illegal=0, timeout=0; wait counter=0.
  - All enables/strobes are 0; all selects are 0.
  - Outputs decode combinationally from state, so this holds throughout reset.
- Reset mid-operation aborts immediately, including during a wait state. No write strobe stays high after reset asserts.
- Transitions, one per rising edge:
  - IDLE -> FETCH.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
    - While mem_ready=0: hold state; ir_write=0, pc_write=0.
    - When mem_ready=1: ir_write=1, pc_write=1, next DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Opcode is latched internally at exit.
    - 35 or 43 -> MEM_ADDR
    - 0 -> EXECUTE
    - 4 or 5 -> BRANCH
    - any other -> TRAP with illegal=1
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ: mem_read=1, i_or_d=1; wait for mem_ready; next MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1, held until mem_ready=1; next FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
    - pc_write = zero for beq; pc_write = ~zero for bne.
    - Next FETCH.
  - TRAP: all strobes 0; remains until reset.
- mem_read and mem_write are never both 1.
- Wait counter:
  - Clears on entry to each memory state.
  - Increments each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT with mem_ready still 0: timeout=1, next TRAP.
  - mem_ready=1 on the same cycle as the limit wins; no trap.
- Latency with mem_ready tied to 1:
  - lw 5 cycles; sw 4; R-format 4; beq/bne 3.
  - Each memory wait cycle adds 1.

Optional Feature:
PERF_COUNT_EN
- Defined: adds outputs cycle_count[31:0] and instr_count[31:0], both reset to 0.
  - cycle_count increments every cycle the state is not IDLE or TRAP.
  - instr_count increments on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB or BRANCH.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- mem_ready=1, opcode=0 (add) -> states 1,2,7,8,1; reg_write=1 and reg_dst=1 only in R_WB; alu_op=10 in EXECUTE.
- mem_ready=1, opcode=35 -> states 1,2,3,4,5,1; i_or_d=1 and mem_read=1 in MEM_READ; mem_to_reg=1 in MEM_WB.
- opcode=43 with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held for 4 cycles, then FETCH; no reg_write.
- opcode=4, zero=1 -> pc_write=1 in BRANCH; opcode=5, zero=1 -> pc_write=0; opcode=5, zero=0 -> pc_write=1.
- opcode=6'h3F -> TRAP after DECODE, illegal=1, all strobes 0; reset low -> state=0 and illegal=0 asynchronously.
- MAX_WAIT=4, mem_ready stuck 0 in FETCH -> timeout=1 and state=10 after 4 wait cycles; with PERF_COUNT_EN, three R-format instructions -> instr_count=3, cycle_count=13.
